// File: rtl/password_checker_if.sv
// Digit entry, storage read port and status bundle
// for the password checker.
interface password_checker_if;
   logic       enable;
   logic [3:0] digit;
   logic [3:0] rdData;
   logic [1:0] rdAddress;
   logic       unlocked;
   logic       error;
   logic       alarm;
   logic [2:0] failCount;
   logic [2:0] dbgState;

   modport master (
      output enable, digit, rdData,
      input  rdAddress, unlocked, error,
      input  alarm, failCount, dbgState
   );

   modport slave (
      input  enable, digit, rdData,
      output rdAddress, unlocked, error,
      output alarm, failCount, dbgState
   );
endinterface

// File: rtl/password_checker.sv
// Serial 4-digit password checker with
// consecutive-failure counting and alarm latch.
module password_checker #(
   parameter int unsigned MAX_FAILS = 3
) (
   input logic CLK,
   input logic RST,
   password_checker_if.slave bus
);

   typedef enum logic [2:0] {
      S_C0    = 3'd0,
      S_C1    = 3'd1,
      S_C2    = 3'd2,
      S_C3    = 3'd3,
      S_PASS  = 3'd4,
      S_FAIL  = 3'd5,
      S_ALARM = 3'd6
   } state_t;

   state_t     state;
   logic       mismatch;
   logic [2:0] fail_count;

   logic       hit;
   logic       final_miss;
   logic [3:0] fail_inc;
   logic       at_limit;

   assign hit        = (bus.digit == bus.rdData);
   assign final_miss = mismatch | ~hit;
   assign fail_inc   = {1'b0, fail_count} + 4'd1;
   assign at_limit   = (fail_inc >= 4'(MAX_FAILS));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state      <= S_C0;
         mismatch   <= 1'b0;
         fail_count <= 3'd0;
      end else begin
         case (state)
            S_C0: if (bus.enable) begin
               mismatch <= ~hit;
               state    <= S_C1;
            end
            S_C1: if (bus.enable) begin
               mismatch <= mismatch | ~hit;
               state    <= S_C2;
            end
            S_C2: if (bus.enable) begin
               mismatch <= mismatch | ~hit;
               state    <= S_C3;
            end
            S_C3: if (bus.enable) begin
               mismatch <= final_miss;
               if (!final_miss) begin
                  state      <= S_PASS;
                  fail_count <= 3'd0;
               end else if (at_limit) begin
                  state      <= S_ALARM;
                  fail_count <= 3'(MAX_FAILS);
               end else begin
                  state      <= S_FAIL;
                  fail_count <= fail_inc[2:0];
               end
            end
            // A digit here opens the next attempt at address 0
            S_PASS, S_FAIL: if (bus.enable) begin
               mismatch <= ~hit;
               state    <= S_C1;
            end
            S_ALARM: state <= S_ALARM;
            default: state <= S_C0;
         endcase
      end
   end

   assign bus.rdAddress = state[2] ? 2'd0 : state[1:0];
   assign bus.unlocked  = (state == S_PASS);
   assign bus.error     = (state == S_FAIL) ||
                          (state == S_ALARM);
   assign bus.alarm     = (state == S_ALARM);
   assign bus.failCount = fail_count;
   assign bus.dbgState  = state;

endmodule

// File: tb/tb_password_checker.sv
// Scoreboard bench for password_checker: expected
// state/failCount queued per cycle, popped after the edge.
module tb_password_checker;

   logic CLK;
   logic RST;
   logic [3:0] store [4];

   password_checker_if bus ();

   password_checker #(.MAX_FAILS(3)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   assign bus.rdData = store[bus.rdAddress];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [2:0] st;
      logic [2:0] fc;
   } exp_t;

   exp_t sb [$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
      end
   endtask

   task automatic push(input string tag,
                       input logic [2:0] st,
                       input logic [2:0] fc);
      exp_t e;
      e.tag = tag;
      e.st  = st;
      e.fc  = fc;
      sb.push_back(e);
   endtask

   task automatic verify();
      exp_t e;
      logic [1:0] ra;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: got 0 entries expected 1");
         return;
      end
      e  = sb.pop_front();
      ra = e.st[2] ? 2'd0 : e.st[1:0];
      chk({e.tag, ".state"}, 32'(bus.dbgState), 32'(e.st));
      chk({e.tag, ".fc"}, 32'(bus.failCount), 32'(e.fc));
      chk({e.tag, ".unl"}, 32'(bus.unlocked),
          32'(e.st == 3'd4));
      chk({e.tag, ".err"}, 32'(bus.error),
          32'(e.st == 3'd5 || e.st == 3'd6));
      chk({e.tag, ".alm"}, 32'(bus.alarm),
          32'(e.st == 3'd6));
      chk({e.tag, ".addr"}, 32'(bus.rdAddress), 32'(ra));
   endtask

   task automatic step(input string tag,
                       input logic en,
                       input logic [3:0] d,
                       input logic [2:0] st,
                       input logic [2:0] fc);
      @(negedge CLK);
      bus.enable = en;
      bus.digit  = d;
      push(tag, st, fc);
      @(posedge CLK);
      #1;
      verify();
   endtask

   task automatic idle(input string tag,
                       input logic [2:0] st,
                       input logic [2:0] fc);
      step(tag, 1'b0, 4'($urandom_range(0, 15)), st, fc);
   endtask

   task automatic do_reset(input string tag);
      @(negedge CLK);
      bus.enable = 1'b0;
      #2;
      RST = 1'b0;
      push(tag, 3'd0, 3'd0);
      #1;
      verify();
      @(negedge CLK);
      RST = 1'b1;
   endtask

   initial begin
      RST        = 1'b0;
      bus.enable = 1'b0;
      bus.digit  = 4'd0;
      store[0] = 4'd1;
      store[1] = 4'd2;
      store[2] = 4'd3;
      store[3] = 4'd4;
      #1;
      push("rst", 3'd0, 3'd0);
      verify();
      repeat (2) @(negedge CLK);
      RST = 1'b1;

      // correct entry
      step("p1a", 1, 4'd1, 3'd1, 3'd0);
      step("p1b", 1, 4'd2, 3'd2, 3'd0);
      step("p1c", 1, 4'd3, 3'd3, 3'd0);
      step("p1d", 1, 4'd4, 3'd4, 3'd0);
      idle("p1h", 3'd4, 3'd0);

      // one wrong digit, then retry from S_FAIL
      step("f1a", 1, 4'd1, 3'd1, 3'd0);
      step("f1b", 1, 4'd9, 3'd2, 3'd0);
      step("f1c", 1, 4'd3, 3'd3, 3'd0);
      step("f1d", 1, 4'd4, 3'd5, 3'd1);
      idle("f1h", 3'd5, 3'd1);
      step("r1a", 1, 4'd1, 3'd1, 3'd1);
      step("r1b", 1, 4'd2, 3'd2, 3'd1);
      step("r1c", 1, 4'd3, 3'd3, 3'd1);
      step("r1d", 1, 4'd4, 3'd4, 3'd0);

      // three wrong attempts reach the alarm
      for (int a = 1; a <= 3; a++) begin
         step("w_a", 1, 4'd0, 3'd1, 3'(a - 1));
         step("w_b", 1, 4'd0, 3'd2, 3'(a - 1));
         step("w_c", 1, 4'd0, 3'd3, 3'(a - 1));
         step("w_d", 1, 4'd0,
              (a == 3) ? 3'd6 : 3'd5, 3'(a));
      end
      for (int i = 0; i < 4; i++)
         step("alm_hold", 1, 4'(i + 1), 3'd6, 3'd3);
      do_reset("rst_alm");

      // async reset mid-attempt
      step("m_a", 1, 4'd1, 3'd1, 3'd0);
      step("m_b", 1, 4'd2, 3'd2, 3'd0);
      do_reset("rst_mid");
      step("m2a", 1, 4'd1, 3'd1, 3'd0);
      step("m2b", 1, 4'd2, 3'd2, 3'd0);
      step("m2c", 1, 4'd3, 3'd3, 3'd0);
      step("m2d", 1, 4'd4, 3'd4, 3'd0);

      // gaps between digits
      for (int k = 0; k < 4; k++) begin
         step("g_dig", 1, 4'(k + 1),
              (k == 3) ? 3'd4 : 3'(k + 1), 3'd0);
         for (int g = 0; g < 5; g++)
            idle("g_hold",
                 (k == 3) ? 3'd4 : 3'(k + 1), 3'd0);
      end

      // one wrong then enable held high four cycles
      step("h0a", 1, 4'd5, 3'd1, 3'd0);
      step("h0b", 1, 4'd2, 3'd2, 3'd0);
      step("h0c", 1, 4'd3, 3'd3, 3'd0);
      step("h0d", 1, 4'd4, 3'd5, 3'd1);
      for (int i = 0; i < 4; i++) store[i] = 4'd7;
      step("h_a", 1, 4'd7, 3'd1, 3'd1);
      step("h_b", 1, 4'd7, 3'd2, 3'd1);
      step("h_c", 1, 4'd7, 3'd3, 3'd1);
      step("h_d", 1, 4'd7, 3'd4, 3'd0);
      idle("h_e", 3'd4, 3'd0);

      // storage change mid-attempt is honoured
      step("s_a", 1, 4'd7, 3'd1, 3'd0);
      store[1] = 4'd8;
      step("s_b", 1, 4'd8, 3'd2, 3'd0);
      step("s_c", 1, 4'd7, 3'd3, 3'd0);
      step("s_d", 1, 4'd7, 3'd4, 3'd0);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected done");
      $fatal(1);
   end

endmodule

// File: doc/password_checker.md
Name: password_checker

Overview:
- Reader-side counterpart of the password-setting logic in the serial password lock.
- Takes entered digits serially, one per `enable` pulse, and reads the stored 4-digit password from the shared 4x4-bit password storage through a combinational read port.
- Compares each entered digit against the stored digit, reports pass or fail after the fourth digit, and counts consecutive failures until it latches an alarm.

Parameters:
- MAX_FAILS, 3: consecutive failed attempts that enter the alarm state; legal range 1..7.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  reset, asynchronous, active-low.
- enable  input  1  one-cycle pulse per entered digit; each high cycle counts as one digit.
- digit  input  4  entered digit; sampled only when enable=1.
- rdData  input  4  stored digit at rdAddress, returned combinationally by storage in the same cycle.
- rdAddress  output  2  storage read address; index of the digit currently expected.
- unlocked  output  1  high while in S_PASS.
- error  output  1  high while in S_FAIL or S_ALARM.
- alarm  output  1  high while in S_ALARM.
- failCount  output  3  consecutive failed attempts, saturating at MAX_FAILS.
- dbgState  output  3  current state encoding, for debug.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=S_C0, mismatch=0, failCount=0.
  - unlocked=0, error=0, alarm=0, rdAddress=0.
  - Reset asserted mid-attempt discards all partial comparison results.
- State encoding (dbgState): S_C0=0, S_C1=1, S_C2=2, S_C3=3, S_PASS=4, S_FAIL=5, S_ALARM=6. Encoding 7 is unreachable; if ever reached, return to S_C0 on the next edge.
- Outputs are decoded from the state register only, so they change one cycle after the enable edge that caused the transition.
- rdAddress:
  - S_Ck -> k.
  - S_PASS, S_FAIL, S_ALARM -> 0, so the next attempt's first digit is compared in the same cycle as its enable pulse.
- Compare rule, on an enable cycle in S_C0..S_C3 or in S_PASS/S_FAIL: hit = (digit == rdData).
- mismatch register:
  - Cleared by the first digit of each attempt, then loaded with !hit.
  - On later digits of the same attempt: mismatch <= mismatch | !hit.
- Transitions (taken only when enable=1; otherwise hold all state):
  - S_C0 -> S_C1 -> S_C2 -> S_C3, updating mismatch on each digit.
  - S_C3 with final = mismatch | !hit:
    - final=0 -> S_PASS; failCount <= 0.
    - final=1 and failCount+1 >= MAX_FAILS -> S_ALARM; failCount <= MAX_FAILS.
    - final=1 otherwise -> S_FAIL; failCount <= failCount+1.
  - S_PASS or S_FAIL: the enable digit is the first digit of a new attempt. Compare against address 0, set mismatch <= !hit, go to S_C1. unlocked/error drop on the next cycle.
  - S_ALARM: enable ignored; leave only via reset.
- No timeout: a partial attempt waits indefinitely.
- failCount persists across attempts; only a pass or reset clears it.
- A digit that matches by value is never treated as success early; the verdict is issued only after four digits.
- Simultaneous enable and reset: reset wins.
- enable held high N cycles counts as N digits. Debouncing and pulse generation are upstream responsibilities.
- Storage writes from the setter do not coordinate with this block. If the password is changed mid-attempt, later digits compare against the new contents.

Test Plan:
- Storage {1,2,3,4}; enter 1,2,3,4 -> cycle after the 4th pulse: unlocked=1, error=0, failCount=0, dbgState=4, rdAddress=0.
- Storage {1,2,3,4}; enter 1,9,3,4 -> error=1, unlocked=0, dbgState=5, failCount=1. Then enter 1,2,3,4 directly (first digit taken in S_FAIL) -> unlocked=1, failCount=0.
- MAX_FAILS=3; three wrong attempts 0,0,0,0 -> failCount 1, 2, then dbgState=6, alarm=1, error=1, failCount=3. Further pulses with 1,2,3,4 -> no state change. RST low -> all outputs 0, dbgState=0.
- Storage {1,2,3,4}; enter 1,2 then assert RST asynchronously between edges -> outputs clear immediately. Enter 1,2,3,4 -> unlocked=1.
- Gaps between pulses (enable low 5 cycles between digits) -> rdAddress steps 0,1,2,3 and holds during gaps; correct verdict after the 4th pulse.
- enable held high 4 consecutive cycles with digit constant 7 and storage {7,7,7,7} -> unlocked=1 on the 5th cycle.
